// File: rtl/bfly_feeder.sv
// Butterfly input feeder: buffers one 2*HALF-beat frame of LANES complex samples,
// then streams HALF contiguous pair-beats (upper[k], lower[k]) with bfly_en held high.

module bfly_feeder_lane #(
    parameter int WIDTH = 10,
    parameter int HALF  = 16,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_i,
    input  logic [WIDTH-1:0] i_wr_q,
    input  logic             i_rd_ld,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_d1_i,
    output logic [WIDTH-1:0] o_d1_q,
    output logic [WIDTH-1:0] o_d2_i,
    output logic [WIDTH-1:0] o_d2_q
);
    // Beat index doubles as buffer address: upper half at 0..HALF-1, lower at HALF..2*HALF-1.
    logic [WIDTH-1:0] r_mem_i [2*HALF];
    logic [WIDTH-1:0] r_mem_q [2*HALF];
    logic [AW-1:0]    w_lo_addr;

    assign w_lo_addr = i_rd_addr + AW'(HALF);

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem_i[i_wr_addr] <= i_wr_i;
            r_mem_q[i_wr_addr] <= i_wr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_d1_i <= '0;
            o_d1_q <= '0;
            o_d2_i <= '0;
            o_d2_q <= '0;
        end else if (i_rd_ld) begin
            o_d1_i <= r_mem_i[i_rd_addr];
            o_d1_q <= r_mem_q[i_rd_addr];
            o_d2_i <= r_mem_i[w_lo_addr];
            o_d2_q <= r_mem_q[w_lo_addr];
        end
    end
endmodule

module bfly_feeder #(
    parameter int INT   = 4,
    parameter int FLT   = 6,
    parameter int WIDTH = INT + FLT,
    parameter int LANES = 16,
    parameter int HALF  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                din_valid,
    output logic                                din_ready,
    input  logic                                din_sof,
    input  logic signed [0:LANES-1][WIDTH-1:0]  din_i,
    input  logic signed [0:LANES-1][WIDTH-1:0]  din_q,
    output logic                                bfly_en,
    output logic signed [0:LANES-1][WIDTH-1:0]  dout1_i,
    output logic signed [0:LANES-1][WIDTH-1:0]  dout1_q,
    output logic signed [0:LANES-1][WIDTH-1:0]  dout2_i,
    output logic signed [0:LANES-1][WIDTH-1:0]  dout2_q,
    output logic                                frame_done,
    output logic                                sof_err
);
    localparam int AW = $clog2(2 * HALF);
    localparam int EW = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT} state_t;

    state_t        r_state;
    logic [AW-1:0] r_beat;
    logic [EW-1:0] r_emit;

    logic          w_accept;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic          w_last_beat;
    logic          w_emit_more;
    logic          w_rd_ld;
    logic [EW-1:0] w_rd_idx;
    logic [AW-1:0] w_rd_addr;

    assign w_accept    = din_valid & din_ready;
    // A sof beat always lands at upper[0]; orphan beats in IDLE are never written.
    assign w_wr_en     = w_accept & (din_sof | (r_state == S_FILL));
    assign w_wr_addr   = din_sof ? '0 : r_beat;
    assign w_last_beat = w_accept & ~din_sof & (r_state == S_FILL) & (r_beat == AW'(2*HALF-1));
    assign w_emit_more = (r_state == S_EMIT) & (r_emit != EW'(HALF-1));
    assign w_rd_ld     = w_last_beat | w_emit_more;
    assign w_rd_idx    = w_last_beat ? '0 : r_emit + EW'(1);
    assign w_rd_addr   = AW'(w_rd_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_emit     <= '0;
            din_ready  <= 1'b0;
            bfly_en    <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            sof_err    <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    din_ready <= 1'b1;
                    if (w_accept) begin
                        if (din_sof) begin
                            r_beat  <= AW'(1);
                            r_state <= S_FILL;
                        end else begin
                            sof_err <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    din_ready <= 1'b1;
                    if (w_accept) begin
                        if (din_sof) begin
                            r_beat  <= AW'(1);
                            sof_err <= 1'b1;
                        end else if (w_last_beat) begin
                            r_beat     <= '0;
                            r_emit     <= '0;
                            r_state    <= S_EMIT;
                            din_ready  <= 1'b0;
                            bfly_en    <= 1'b1;
                            frame_done <= (w_rd_idx == EW'(HALF-1));
                        end else begin
                            r_beat <= r_beat + AW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    // No stall path: the burst runs to completion once started.
                    if (r_emit == EW'(HALF-1)) begin
                        r_emit    <= '0;
                        r_state   <= S_IDLE;
                        bfly_en   <= 1'b0;
                        din_ready <= 1'b1;
                    end else begin
                        r_emit     <= r_emit + EW'(1);
                        frame_done <= (w_rd_idx == EW'(HALF-1));
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bfly_feeder_lane #(.WIDTH(WIDTH), .HALF(HALF), .AW(AW)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (w_wr_addr),
            .i_wr_i    (din_i[l]),
            .i_wr_q    (din_q[l]),
            .i_rd_ld   (w_rd_ld),
            .i_rd_addr (w_rd_addr),
            .o_d1_i    (dout1_i[l]),
            .o_d1_q    (dout1_q[l]),
            .o_d2_i    (dout2_i[l]),
            .o_d2_q    (dout2_q[l])
        );
    end
endmodule
